// File: rtl/adc_meas_averager_pkg.sv
// Shared types and default constants for the ADC measurement averager.
// The parameter defaults of the block are drawn from the calibration constants here.
package adc_meas_averager_pkg;

    localparam int ADC_WIDTH         = 12;
    localparam int NUM_OUTPUTS       = 2;
    localparam int CAL_SETTLE_CYCLES = 16;
    localparam int CAL_AVG_SAMPLES   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACCUM  = 2'd2,
        DONE   = 2'd3
    } meas_state_t;

endpackage

// File: rtl/meas_channel_acc.sv
// One detector channel: signed accumulator with clear/enable, extreme-code detect,
// and the floor average of the value the accumulator is about to take.
module meas_channel_acc #(
    parameter int ADC_WIDTH = 12,
    parameter int AVG_LOG2  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 enable,
    input  logic [ADC_WIDTH-1:0] sample,
    output logic [ADC_WIDTH-1:0] avg_next,
    output logic                 sat_next
);

    localparam int ACC_WIDTH = ADC_WIDTH + AVG_LOG2;

    function automatic logic is_extreme(input logic [ADC_WIDTH-1:0] s);
        return (s == {1'b0, {(ADC_WIDTH-1){1'b1}}}) || (s == {1'b1, {(ADC_WIDTH-1){1'b0}}});
    endfunction

    logic signed [ACC_WIDTH-1:0] acc_r;
    logic signed [ACC_WIDTH-1:0] acc_next_s;
    logic signed [ACC_WIDTH-1:0] sample_ext_s;
    logic signed [ACC_WIDTH-1:0] shifted_s;
    logic                        sat_r;

    assign sample_ext_s = ACC_WIDTH'($signed(sample));

    // Next accumulator and saturation state; the average is taken from the
    // post-update value so the final sample is included on the same edge.
    always_comb begin
        acc_next_s = acc_r;
        sat_next   = sat_r;
        if (clear) begin
            acc_next_s = {ACC_WIDTH{1'b0}};
            sat_next   = 1'b0;
        end else if (enable) begin
            acc_next_s = acc_r + sample_ext_s;
            sat_next   = sat_r | is_extreme(sample);
        end else begin
            acc_next_s = acc_r;
            sat_next   = sat_r;
        end
    end

    assign shifted_s = acc_next_s >>> AVG_LOG2;
    assign avg_next  = shifted_s[ADC_WIDTH-1:0];

    // Accumulator and sticky saturation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= {ACC_WIDTH{1'b0}};
            sat_r <= 1'b0;
        end else begin
            acc_r <= acc_next_s;
            sat_r <= sat_next;
        end
    end

endmodule

// File: rtl/adc_meas_averager.sv
// Measurement front-end: settle delay, power-of-two sample averaging per channel,
// registered one-cycle result strobe with a per-measurement saturation flag.
module adc_meas_averager #(
    parameter int ADC_WIDTH     = adc_meas_averager_pkg::ADC_WIDTH,
    parameter int NUM_OUTPUTS   = adc_meas_averager_pkg::NUM_OUTPUTS,
    parameter int SETTLE_CYCLES = adc_meas_averager_pkg::CAL_SETTLE_CYCLES,
    parameter int AVG_SAMPLES   = adc_meas_averager_pkg::CAL_AVG_SAMPLES
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             meas_req,
    input  logic                             meas_abort,
    input  logic                             adc_valid,
    input  logic [NUM_OUTPUTS*ADC_WIDTH-1:0] adc_data,
    output logic                             meas_busy,
    output logic                             meas_valid,
    output logic [NUM_OUTPUTS*ADC_WIDTH-1:0] meas_data,
    output logic                             meas_saturated
);

    import adc_meas_averager_pkg::*;

    localparam int AVG_LOG2  = $clog2(AVG_SAMPLES);
    localparam int ACC_WIDTH = ADC_WIDTH + AVG_LOG2;
    localparam int SETTLE_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int SAMP_W    = (AVG_SAMPLES > 1) ? $clog2(AVG_SAMPLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST =
        SETTLE_W'((SETTLE_CYCLES > 0) ? (SETTLE_CYCLES - 1) : 0);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(AVG_SAMPLES - 1);

    meas_state_t                      state_r;
    meas_state_t                      state_next_s;
    logic [SETTLE_W-1:0]              settle_cnt_r;
    logic [SETTLE_W-1:0]              settle_cnt_next_s;
    logic [SAMP_W-1:0]                samp_cnt_r;
    logic [SAMP_W-1:0]                samp_cnt_next_s;
    logic                             clear_s;
    logic                             accept_s;
    logic                             finish_s;
    logic [NUM_OUTPUTS*ADC_WIDTH-1:0] avg_next_s;
    logic [NUM_OUTPUTS-1:0]           sat_vec_s;
    logic                             busy_r;
    logic                             valid_r;
    logic [NUM_OUTPUTS*ADC_WIDTH-1:0] data_r;
    logic                             sat_r;

    // Next-state and counter control; abort outranks every other transition.
    always_comb begin
        state_next_s      = state_r;
        settle_cnt_next_s = settle_cnt_r;
        samp_cnt_next_s   = samp_cnt_r;
        clear_s           = 1'b0;
        accept_s          = 1'b0;
        finish_s          = 1'b0;
        case (state_r)
            IDLE: begin
                if (meas_req) begin
                    clear_s           = 1'b1;
                    settle_cnt_next_s = {SETTLE_W{1'b0}};
                    samp_cnt_next_s   = {SAMP_W{1'b0}};
                    state_next_s      = (SETTLE_CYCLES == 0) ? ACCUM : SETTLE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            SETTLE: begin
                if (meas_abort) begin
                    state_next_s = IDLE;
                end else if (settle_cnt_r == SETTLE_LAST) begin
                    state_next_s = ACCUM;
                end else begin
                    settle_cnt_next_s = settle_cnt_r + SETTLE_W'(1);
                end
            end
            ACCUM: begin
                if (meas_abort) begin
                    state_next_s = IDLE;
                end else if (adc_valid) begin
                    accept_s = 1'b1;
                    if (samp_cnt_r == SAMP_LAST) begin
                        finish_s     = 1'b1;
                        state_next_s = DONE;
                    end else begin
                        samp_cnt_next_s = samp_cnt_r + SAMP_W'(1);
                    end
                end else begin
                    state_next_s = ACCUM;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_chan
        meas_channel_acc #(
            .ADC_WIDTH (ADC_WIDTH),
            .AVG_LOG2  (AVG_LOG2)
        ) u_acc (
            .clk      (clk),
            .rst_n    (rst_n),
            .clear    (clear_s),
            .enable   (accept_s),
            .sample   (adc_data[k*ADC_WIDTH +: ADC_WIDTH]),
            .avg_next (avg_next_s[k*ADC_WIDTH +: ADC_WIDTH]),
            .sat_next (sat_vec_s[k])
        );
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            settle_cnt_r <= {SETTLE_W{1'b0}};
            samp_cnt_r   <= {SAMP_W{1'b0}};
        end else begin
            state_r      <= state_next_s;
            settle_cnt_r <= settle_cnt_next_s;
            samp_cnt_r   <= samp_cnt_next_s;
        end
    end

    // Output registers: the result is captured on the edge that accepts the last
    // sample, so it is presented during DONE and held until the next completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= {(NUM_OUTPUTS*ADC_WIDTH){1'b0}};
            sat_r   <= 1'b0;
        end else begin
            busy_r  <= (state_next_s != IDLE);
            valid_r <= finish_s;
            if (finish_s) begin
                data_r <= avg_next_s;
                sat_r  <= |sat_vec_s;
            end else begin
                data_r <= data_r;
                sat_r  <= sat_r;
            end
        end
    end

    assign meas_busy      = busy_r;
    assign meas_valid     = valid_r;
    assign meas_data      = data_r;
    assign meas_saturated = sat_r;

    logic unused_acc_width;
    assign unused_acc_width = (ACC_WIDTH > 0);

endmodule

// File: tb/tb_adc_meas_averager.sv
// Self-checking bench: randomized measurements against a cycle-level behavioural
// model (sample acceptance window, floor average, extreme-code flag).
module tb_adc_meas_averager;

    localparam int W  = 12;
    localparam int S  = 16;
    localparam int N  = 8;
    localparam int DW = 2 * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          meas_req, meas_abort, adc_valid;
    logic [DW-1:0] adc_data;
    logic          meas_busy, meas_valid, meas_saturated;
    logic [DW-1:0] meas_data;

    logic          req1, abort1, valid1;
    logic [DW-1:0] data1;
    logic          busy1, mv1, ms1;
    logic [DW-1:0] md1;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] held_data = '0;
    logic          held_sat  = 1'b0;
    int pat0[8];
    int pat1[8];

    always #5 clk = ~clk;

    adc_meas_averager dut (
        .clk(clk), .rst_n(rst_n), .meas_req(meas_req), .meas_abort(meas_abort),
        .adc_valid(adc_valid), .adc_data(adc_data), .meas_busy(meas_busy),
        .meas_valid(meas_valid), .meas_data(meas_data), .meas_saturated(meas_saturated)
    );

    adc_meas_averager #(.SETTLE_CYCLES(0), .AVG_SAMPLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .meas_req(req1), .meas_abort(abort1),
        .adc_valid(valid1), .adc_data(data1), .meas_busy(busy1),
        .meas_valid(mv1), .meas_data(md1), .meas_saturated(ms1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pack(input int a, input int b);
        logic [31:0] ua, ub;
        ua = a;
        ub = b;
        return {ub[W-1:0], ua[W-1:0]};
    endfunction

    function automatic bit extreme(input int x);
        return (x == 2047) || (x == -2048);
    endfunction

    function automatic int floor_div(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int rnd_mid();
        return int'($urandom_range(0, 4000)) - 2000;
    endfunction

    function automatic int rnd_full();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return 2047;
        if (r == 1) return -2048;
        return int'($urandom_range(0, 4095)) - 2048;
    endfunction

    // One measurement on the default instance. vmode 0: adc_valid always high,
    // 1: high one cycle in three. dmode 0: constant 100/-100, 1: mid-range random,
    // 2: pat0/pat1 by accepted-sample index, 3: full-range random.
    task automatic measure(input string tag, input int vmode, input int dmode,
                           input int abort_cyc, input bit spam);
        int  acc0[$];
        int  acc1[$];
        int  cnt  = 0;
        int  vcyc = 0;
        bit  done = 1'b0;
        meas_req   = 1'b1;
        meas_abort = 1'b0;
        adc_valid  = 1'b0;
        @(posedge clk);
        #1;
        for (int cyc = 1; cyc <= 300 && !done; cyc++) begin
            bit v;
            int d0, d1;
            v = (vmode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (cyc <= S) begin
                d0 = rnd_full();
                d1 = rnd_full();
            end else begin
                case (dmode)
                    0: begin d0 = 100; d1 = -100; end
                    1: begin d0 = rnd_mid(); d1 = rnd_mid(); end
                    2: begin d0 = (cnt < N) ? pat0[cnt] : 0; d1 = (cnt < N) ? pat1[cnt] : 0; end
                    default: begin d0 = rnd_full(); d1 = rnd_full(); end
                endcase
            end
            adc_valid  = v;
            adc_data   = pack(d0, d1);
            meas_req   = (spam && (vcyc == 0 || cyc <= vcyc) && (abort_cyc == 0 || cyc <= abort_cyc))
                         ? 1'($urandom_range(0, 1)) : 1'b0;
            meas_abort = (cyc == abort_cyc);
            @(negedge clk);
            if (abort_cyc != 0 && cyc == abort_cyc + 1) begin
                chk({tag, ":abort_busy"}, 32'(meas_busy), 32'd0);
                chk({tag, ":abort_valid"}, 32'(meas_valid), 32'd0);
                chk({tag, ":abort_data"}, 32'(meas_data), 32'(held_data));
                chk({tag, ":abort_sat"}, 32'(meas_saturated), 32'(held_sat));
                done = 1'b1;
            end else if (vcyc != 0 && cyc == vcyc + 1) begin
                chk({tag, ":idle_busy"}, 32'(meas_busy), 32'd0);
                chk({tag, ":idle_valid"}, 32'(meas_valid), 32'd0);
                done = 1'b1;
            end else begin
                chk({tag, ":busy"}, 32'(meas_busy), 32'd1);
                chk({tag, ":valid"}, 32'(meas_valid), 32'(cyc == vcyc));
                if (cyc == vcyc) begin
                    int  s0 = 0;
                    int  s1 = 0;
                    bit  es = 1'b0;
                    foreach (acc0[i]) begin
                        s0 += acc0[i];
                        s1 += acc1[i];
                        es |= extreme(acc0[i]) | extreme(acc1[i]);
                    end
                    held_data = pack(floor_div(s0, N), floor_div(s1, N));
                    held_sat  = es;
                    chk({tag, ":data"}, 32'(meas_data), 32'(held_data));
                    chk({tag, ":sat"}, 32'(meas_saturated), 32'(held_sat));
                end
            end
            if (!done && v && cyc > S && cnt < N && (abort_cyc == 0 || cyc < abort_cyc)) begin
                acc0.push_back(d0);
                acc1.push_back(d1);
                cnt++;
                if (cnt == N) vcyc = cyc + 1;
            end
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) chk({tag, ":timeout"}, 32'd0, 32'd1);
        meas_req   = 1'b0;
        meas_abort = 1'b0;
        adc_valid  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        meas_req = 1'b0; meas_abort = 1'b0; adc_valid = 1'b0; adc_data = '0;
        req1 = 1'b0; abort1 = 1'b0; valid1 = 1'b0; data1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(meas_busy), 32'd0);
        chk("rst_valid", 32'(meas_valid), 32'd0);
        chk("rst_data", 32'(meas_data), 32'd0);
        chk("rst_sat", 32'(meas_saturated), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        measure("const", 0, 0, 0, 1'b0);

        pat0 = '{0, 0, 0, 0, 0, 0, 0, -1};
        pat1 = '{1, 1, 1, 1, 1, 1, 1, 0};
        measure("round_a", 0, 2, 0, 1'b0);
        pat0 = '{1, 1, 1, 1, 1, 1, 1, 0};
        pat1 = '{-3, 5, -7, 2, -1, 0, -9, 4};
        measure("round_b", 0, 2, 0, 1'b0);

        pat0 = '{300, -200, 150, 7, -80, 900, -1000, 33};
        pat1 = '{10, 20, 30, 2047, 40, -50, 60, -70};
        measure("sat", 0, 2, 0, 1'b0);
        measure("clean", 0, 1, 0, 1'b0);

        measure("toggle", 1, 1, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            measure("random", int'($urandom_range(0, 1)), 3, 0, 1'($urandom_range(0, 1)));
        end

        measure("abort", 0, 1, 20, 1'b1);

        // Asynchronous reset in the middle of accumulation.
        meas_req = 1'b1;
        @(posedge clk);
        #1;
        meas_req  = 1'b0;
        adc_valid = 1'b1;
        adc_data  = pack(5, 6);
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(meas_busy), 32'd0);
        chk("arst_valid", 32'(meas_valid), 32'd0);
        chk("arst_data", 32'(meas_data), 32'd0);
        chk("arst_sat", 32'(meas_saturated), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        adc_valid = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(meas_busy), 32'd0);
        measure("post_rst", 0, 1, 0, 1'b0);

        // Zero settle, single-sample configuration.
        for (int i = 0; i < 6; i++) begin
            int d0, d1;
            d0 = rnd_full();
            d1 = rnd_full();
            req1 = 1'b1;
            @(posedge clk);
            #1;
            req1   = 1'b0;
            valid1 = 1'b1;
            data1  = pack(d0, d1);
            @(negedge clk);
            chk("s0_busy_c1", 32'(busy1), 32'd1);
            chk("s0_valid_c1", 32'(mv1), 32'd0);
            @(posedge clk);
            #1;
            valid1 = 1'b0;
            data1  = pack(rnd_full(), rnd_full());
            @(negedge clk);
            chk("s0_valid_c2", 32'(mv1), 32'd1);
            chk("s0_data", 32'(md1), 32'(pack(d0, d1)));
            chk("s0_sat", 32'(ms1), 32'(extreme(d0) || extreme(d1)));
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("s0_idle_busy", 32'(busy1), 32'd0);
            chk("s0_idle_valid", 32'(mv1), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
